core_result_reducer: RTL and testbench

Parametrised result-collection unit between the worker-core array and the master core. Replaces the flat combinational N-way select plus wide AND of done flags with a registered reducer. It waits for all workers to finish, then scans their (key, payload) pairs LANES per cycle. It returns the min or max key with its payload and core index. A registered random-access read port is kept for per-core inspection by the master.

---
 rtl/core_reduce_pkg.sv | 30 +++
 rtl/reduce_lane_cmp.sv | 54 +++++
 rtl/core_result_reducer.sv | 222 ++++++++++++++++++++++
 tb/tb_core_result_reducer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_reduce_pkg.sv
// core_reduce_pkg
// Shared types and constant helpers for the result reducer.
//   state_t      : reducer FSM states
//   MODE_MIN/MAX : encodings of the reduction direction input
//   clog2_min1   : index width, never less than 1
//   ceil_div     : number of scan groups
package core_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    SCAN      = 2'd2,
    RESULT    = 2'd3
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 31) && ((32'd1 << w) < n)) w++;
    return w;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/reduce_lane_cmp.sv
// reduce_lane_cmp
// Combinational LANES-wide selection of the best (key, payload) pair.
//   i_keys/i_payloads : LANES packed entries, lane l at [l*DATA_W +: DATA_W]
//   i_base_idx        : core index of lane 0
//   i_valid           : per-lane valid mask
//   i_mode            : 0 = min, 1 = max (unsigned keys)
//   o_key/o_payload/o_idx : winning entry
//   o_any             : at least one lane was valid
module reduce_lane_cmp
  import core_reduce_pkg::*;
#(
  parameter int unsigned LANES  = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic [LANES*DATA_W-1:0] i_keys,
  input  logic [LANES*DATA_W-1:0] i_payloads,
  input  logic [IDX_W-1:0]        i_base_idx,
  input  logic [LANES-1:0]        i_valid,
  input  logic                    i_mode,
  output logic [DATA_W-1:0]       o_key,
  output logic [DATA_W-1:0]       o_payload,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_any
);

  function automatic logic key_better(input logic mode,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    return (mode == MODE_MAX) ? (a > b) : (a < b);
  endfunction

  logic [DATA_W-1:0] w_k;

  // Ascending-index priority fold: a later lane only replaces the current
  // winner when strictly better, so equal keys keep the lower index.
  always_comb begin
    o_any     = 1'b0;
    o_key     = '0;
    o_payload = '0;
    o_idx     = '0;
    w_k       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_k = i_keys[l*DATA_W +: DATA_W];
      if (i_valid[l] && (!o_any || key_better(i_mode, w_k, o_key))) begin
        o_any     = 1'b1;
        o_key     = w_k;
        o_payload = i_payloads[l*DATA_W +: DATA_W];
        o_idx     = i_base_idx + IDX_W'(l);
      end
    end
  end

endmodule

// File: rtl/core_result_reducer.sv
// core_result_reducer
// Registered min/max reducer over NUM_CORES worker results.
// Waits for every core_done, scans LANES cores per cycle and reports the
// winning key, payload and core index. Also offers a registered random
// access read port onto the per-core key/payload buses.
//   i_clk, i_rst_n             : clock, async active-low reset
//   i_core_key/i_core_payload  : flattened per-core data, core i at [i*DATA_W +: DATA_W]
//   i_core_done                : per-core ready flags
//   i_start, i_mode            : reduction request and direction (0 min, 1 max)
//   o_busy                     : waiting for done or scanning
//   o_all_done                 : registered AND of i_core_done
//   o_res_valid/key/payload/index : completed reduction result
//   i_rd_addr -> o_rd_key/o_rd_payload : 1-cycle read port, 0 when out of range
module core_result_reducer
  import core_reduce_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 61,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned LANES     = 1,
  localparam int unsigned IDX_W     = clog2_min1(NUM_CORES)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_key,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_payload,
  input  logic [NUM_CORES-1:0]        i_core_done,
  input  logic                        i_start,
  input  logic                        i_mode,
  output logic                        o_busy,
  output logic                        o_all_done,
  output logic                        o_res_valid,
  output logic [DATA_W-1:0]           o_res_key,
  output logic [DATA_W-1:0]           o_res_payload,
  output logic [IDX_W-1:0]            o_res_index,
  input  logic [IDX_W-1:0]            i_rd_addr,
  output logic [DATA_W-1:0]           o_rd_key,
  output logic [DATA_W-1:0]           o_rd_payload
);

  localparam int unsigned G    = ceil_div(NUM_CORES, LANES);
  localparam int unsigned GP_W = clog2_min1(G);
  localparam int unsigned PAD  = G * LANES;

  state_t r_state, w_next;

  logic              r_mode;
  logic [GP_W-1:0]   r_grp;
  logic              r_best_vld;
  logic [DATA_W-1:0] r_best_key, r_best_pay;
  logic [IDX_W-1:0]  r_best_idx;
  logic              r_all_done;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_key, r_res_pay;
  logic [IDX_W-1:0]  r_res_idx;
  logic [DATA_W-1:0] r_rd_key, r_rd_pay;

  logic [PAD*DATA_W-1:0]   w_key_pad, w_pay_pad;
  logic [LANES*DATA_W-1:0] w_grp_keys, w_grp_pays;
  logic [LANES-1:0]        w_mask;
  logic [IDX_W-1:0]        w_base;
  logic [DATA_W-1:0]       w_lane_key, w_lane_pay;
  logic [IDX_W-1:0]        w_lane_idx;
  logic                    w_lane_any;
  logic                    w_take_lane;
  logic                    w_last_grp;
  logic [DATA_W-1:0]       w_m_key, w_m_pay;
  logic [IDX_W-1:0]        w_m_idx;
  logic                    w_rd_in_range;
  logic [IDX_W-1:0]        w_rd_sel;

  function automatic logic key_better(input logic mode,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    return (mode == MODE_MAX) ? (a > b) : (a < b);
  endfunction

  // Zero-pad the core buses to a whole number of groups so the last,
  // partial group can be sliced without running off the end; the padded
  // lanes are masked out below.
  always_comb begin : grp_sel
    int unsigned v_base;
    w_key_pad = '0;
    w_pay_pad = '0;
    w_key_pad[NUM_CORES*DATA_W-1:0] = i_core_key;
    w_pay_pad[NUM_CORES*DATA_W-1:0] = i_core_payload;
    v_base     = 32'(r_grp) * LANES;
    w_grp_keys = w_key_pad[v_base*DATA_W +: LANES*DATA_W];
    w_grp_pays = w_pay_pad[v_base*DATA_W +: LANES*DATA_W];
    w_mask     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_mask[l] = (v_base + l) < NUM_CORES;
    end
    w_base = IDX_W'(v_base);
  end

  reduce_lane_cmp #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .i_keys    (w_grp_keys),
    .i_payloads(w_grp_pays),
    .i_base_idx(w_base),
    .i_valid   (w_mask),
    .i_mode    (r_mode),
    .o_key     (w_lane_key),
    .o_payload (w_lane_pay),
    .o_idx     (w_lane_idx),
    .o_any     (w_lane_any)
  );

  // Best-so-far always comes from earlier groups (lower indices), so the
  // group winner only displaces it when strictly better.
  always_comb begin
    w_take_lane = w_lane_any && (!r_best_vld || key_better(r_mode, w_lane_key, r_best_key));
    w_m_key     = w_take_lane ? w_lane_key : r_best_key;
    w_m_pay     = w_take_lane ? w_lane_pay : r_best_pay;
    w_m_idx     = w_take_lane ? w_lane_idx : r_best_idx;
    w_last_grp  = (32'(r_grp) == G - 1);
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, RESULT: if (i_start)    w_next = WAIT_DONE;
      WAIT_DONE:    if (r_all_done) w_next = SCAN;
      SCAN: begin
        if (!r_all_done)     w_next = WAIT_DONE;
        else if (w_last_grp) w_next = RESULT;
      end
      default:              w_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy        = (r_state == WAIT_DONE) || (r_state == SCAN);
    o_all_done    = r_all_done;
    o_res_valid   = r_res_valid;
    o_res_key     = r_res_key;
    o_res_payload = r_res_pay;
    o_res_index   = r_res_idx;
    o_rd_key      = r_rd_key;
    o_rd_payload  = r_rd_pay;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_all_done  <= 1'b0;
      r_mode      <= MODE_MIN;
      r_grp       <= '0;
      r_best_vld  <= 1'b0;
      r_best_key  <= '0;
      r_best_pay  <= '0;
      r_best_idx  <= '0;
      r_res_valid <= 1'b0;
      r_res_key   <= '0;
      r_res_pay   <= '0;
      r_res_idx   <= '0;
    end else begin
      r_all_done <= &i_core_done;
      unique case (r_state)
        IDLE, RESULT: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_res_valid <= 1'b0;
          end
        end
        WAIT_DONE: begin
          r_grp      <= '0;
          r_best_vld <= 1'b0;
        end
        SCAN: begin
          if (!r_all_done) begin
            r_grp      <= '0;
            r_best_vld <= 1'b0;
          end else begin
            r_grp      <= r_grp + 1'b1;
            r_best_vld <= r_best_vld | w_lane_any;
            r_best_key <= w_m_key;
            r_best_pay <= w_m_pay;
            r_best_idx <= w_m_idx;
            if (w_last_grp) begin
              r_res_valid <= 1'b1;
              r_res_key   <= w_m_key;
              r_res_pay   <= w_m_pay;
              r_res_idx   <= w_m_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read port: clamp the select so the part-select never leaves the bus.
  always_comb begin
    w_rd_in_range = 32'(i_rd_addr) < NUM_CORES;
    w_rd_sel      = w_rd_in_range ? i_rd_addr : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_key <= '0;
      r_rd_pay <= '0;
    end else if (w_rd_in_range) begin
      r_rd_key <= i_core_key[32'(w_rd_sel)*DATA_W +: DATA_W];
      r_rd_pay <= i_core_payload[32'(w_rd_sel)*DATA_W +: DATA_W];
    end else begin
      r_rd_key <= '0;
      r_rd_pay <= '0;
    end
  end

endmodule

// File: tb/tb_core_result_reducer.sv
module tb_core_result_reducer;

  localparam int unsigned NC = 61;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC*DW-1:0]  key, pay;
  logic [NC-1:0]     done;
  logic              start, mode;
  logic [IW-1:0]     rd_addr;

  logic              busy_a, alld_a, rv_a, busy_b, alld_b, rv_b;
  logic [DW-1:0]     rk_a, rp_a, rdk_a, rdp_a, rk_b, rp_b, rdk_b, rdp_b;
  logic [IW-1:0]     ri_a, ri_b;

  core_result_reducer #(.NUM_CORES(NC), .DATA_W(DW), .LANES(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_core_key(key), .i_core_payload(pay),
    .i_core_done(done), .i_start(start), .i_mode(mode),
    .o_busy(busy_a), .o_all_done(alld_a), .o_res_valid(rv_a),
    .o_res_key(rk_a), .o_res_payload(rp_a), .o_res_index(ri_a),
    .i_rd_addr(rd_addr), .o_rd_key(rdk_a), .o_rd_payload(rdp_a)
  );

  core_result_reducer #(.NUM_CORES(NC), .DATA_W(DW), .LANES(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_core_key(key), .i_core_payload(pay),
    .i_core_done(done), .i_start(start), .i_mode(mode),
    .o_busy(busy_b), .o_all_done(alld_b), .o_res_valid(rv_b),
    .o_res_key(rk_b), .o_res_payload(rp_b), .o_res_index(ri_b),
    .i_rd_addr(rd_addr), .o_rd_key(rdk_b), .o_rd_payload(rdp_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] k;
    logic [DW-1:0] p;
    int unsigned   idx;
    int unsigned   lat;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  int unsigned cyc = 0;
  int unsigned st_edge = 0;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  logic        rva_q = 1'b0, rvb_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void mon(input string tag, input bit use_a, input logic [DW-1:0] k,
                              input logic [DW-1:0] p, input logic [IW-1:0] i);
    exp_t e;
    if (use_a ? (q_a.size() == 0) : (q_b.size() == 0)) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_unexpected_result: got res_valid 1 expected no result", tag);
      return;
    end
    e = use_a ? q_a.pop_front() : q_b.pop_front();
    chk({tag, "_key"}, 64'(k), 64'(e.k));
    chk({tag, "_payload"}, 64'(p), 64'(e.p));
    chk({tag, "_index"}, 64'(i), 64'(e.idx));
    chk({tag, "_latency"}, 64'(cyc - st_edge), 64'(e.lat));
  endfunction

  // Monitor: compare on each rising res_valid, decoupled from stimulus.
  always @(negedge clk) begin
    if (rv_a && !rva_q) mon("A", 1'b1, rk_a, rp_a, ri_a);
    if (rv_b && !rvb_q) mon("B", 1'b0, rk_b, rp_b, ri_b);
    rva_q = rv_a;
    rvb_q = rv_b;
  end

  task automatic set_core(input int unsigned i, input logic [DW-1:0] k, input logic [DW-1:0] p);
    key[i*DW +: DW] = k;
    pay[i*DW +: DW] = p;
  endtask

  // Data changes only while done is low.
  task automatic drop_done();
    done = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic raise_done();
    done = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic issue_start(input logic m, input bit push, input logic [DW-1:0] k,
                             input logic [DW-1:0] p, input int unsigned idx,
                             input int unsigned lat_a, input int unsigned lat_b);
    exp_t e;
    start   = 1'b1;
    mode    = m;
    st_edge = cyc + 1;
    if (push) begin
      e.k = k; e.p = p; e.idx = idx;
      e.lat = lat_a; q_a.push_back(e);
      e.lat = lat_b; q_b.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned maxc);
    int unsigned n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL result_timeout: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    key = '0; pay = '0; done = '0; start = 1'b0; mode = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    chk("rst_res_valid_a", 64'(rv_a), 64'd0);
    chk("rst_all_done_a", 64'(alld_a), 64'd0);
    chk("rst_res_key_a", 64'(rk_a), 64'd0);
    chk("rst_res_index_b", 64'(ri_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: descending keys, min at core 60 (alone in dut_b's last group)
    for (int unsigned i = 0; i < NC; i++) set_core(i, DW'(1000 - i), DW'(i * 3 + 7));
    done = '1;
    chk("all_done_lag", 64'(alld_a), 64'd0);
    @(negedge clk);
    chk("all_done_set", 64'(alld_a), 64'd1);
    issue_start(1'b0, 1'b1, 32'd940, 32'd187, 60, 62, 17);
    chk("busy_after_start_a", 64'(busy_a), 64'd1);
    chk("busy_after_start_b", 64'(busy_b), 64'd1);
    wait_drain(200);
    repeat (3) @(negedge clk);
    chk("res_hold_valid_a", 64'(rv_a), 64'd1);
    chk("res_hold_index_b", 64'(ri_b), 64'd60);
    chk("idle_busy_a", 64'(busy_a), 64'd0);

    // Read port
    rd_addr = 6'd5;
    @(negedge clk);
    chk("rd5_key_a", 64'(rdk_a), 64'd995);
    chk("rd5_pay_b", 64'(rdp_b), 64'd22);
    rd_addr = 6'd63;
    @(negedge clk);
    chk("rd63_key_a", 64'(rdk_a), 64'd0);
    chk("rd63_pay_a", 64'(rdp_a), 64'd0);

    // T2: all keys equal, min -> lowest index
    drop_done();
    for (int unsigned i = 0; i < NC; i++) set_core(i, 32'd5, DW'(i + 100));
    raise_done();
    issue_start(1'b0, 1'b1, 32'd5, 32'd100, 0, 62, 17);
    wait_drain(200);

    // T3: max tie across groups at cores 30 and 45
    drop_done();
    for (int unsigned i = 0; i < NC; i++) set_core(i, 32'd0, DW'(i * 3 + 7));
    set_core(30, 32'hFFFF_FFFF, 32'd97);
    set_core(45, 32'hFFFF_FFFF, 32'd142);
    raise_done();
    issue_start(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd97, 30, 62, 17);
    wait_drain(200);

    // T4: min tie at 59 and 60 (different groups for LANES=4)
    drop_done();
    for (int unsigned i = 0; i < NC; i++) set_core(i, 32'd100, DW'(i * 3 + 7));
    set_core(59, 32'd1, 32'd184);
    set_core(60, 32'd1, 32'd187);
    raise_done();
    issue_start(1'b0, 1'b1, 32'd1, 32'd184, 59, 62, 17);
    wait_drain(200);

    // T5: max tie at 41 and 42 (same group for LANES=4)
    drop_done();
    for (int unsigned i = 0; i < NC; i++) set_core(i, DW'(i), DW'(i * 3 + 7));
    set_core(41, 32'hFFFF_FFF0, 32'd130);
    set_core(42, 32'hFFFF_FFF0, 32'd133);
    raise_done();
    issue_start(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd130, 41, 62, 17);
    wait_drain(200);

    // T6: abort mid-scan via core_done[17], then full rescan
    drop_done();
    for (int unsigned i = 0; i < NC; i++) set_core(i, DW'(1000 - i), DW'(i * 3 + 7));
    raise_done();
    issue_start(1'b0, 1'b1, 32'd940, 32'd187, 60, 77, 32);
    repeat (9) @(negedge clk);
    done[17] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_a", 64'(busy_a), 64'd1);
    chk("abort_busy_b", 64'(busy_b), 64'd1);
    chk("abort_res_valid_a", 64'(rv_a), 64'd0);
    chk("abort_res_valid_b", 64'(rv_b), 64'd0);
    repeat (2) @(negedge clk);
    done[17] = 1'b1;
    wait_drain(200);

    // T7: asynchronous reset mid-scan
    rd_addr = 6'd5;
    issue_start(1'b0, 1'b0, '0, '0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_a", 64'(busy_a), 64'd0);
    chk("arst_all_done_a", 64'(alld_a), 64'd0);
    chk("arst_res_valid_a", 64'(rv_a), 64'd0);
    chk("arst_res_key_a", 64'(rk_a), 64'd0);
    chk("arst_res_payload_a", 64'(rp_a), 64'd0);
    chk("arst_res_index_a", 64'(ri_a), 64'd0);
    chk("arst_rd_key_a", 64'(rdk_a), 64'd0);
    chk("arst_rd_payload_b", 64'(rdp_b), 64'd0);
    chk("arst_busy_b", 64'(busy_b), 64'd0);
    @(negedge clk);
    done = '0;
    rst_n = 1'b1;
    @(negedge clk);
    issue_start(1'b0, 1'b0, '0, '0, 0, 0, 0);
    chk("post_rst_busy_a", 64'(busy_a), 64'd1);
    chk("post_rst_res_valid_a", 64'(rv_a), 64'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_wait_busy_b", 64'(busy_b), 64'd1);
    chk("post_rst_wait_res_valid_b", 64'(rv_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
